single_port_ram: RTL and testbench
==================================

Name: single_port_ram

Overview:
- Synchronous single-port RAM: one shared address bus for reads and writes, one write-enable, one registered read-data output.
- Generic on-chip storage primitive for scratchpads, register files and small buffers in the CPU datapath.
- Written so synthesis infers block or distributed RAM. The storage array itself is never reset.

Parameters:
- ADDR_WIDTH, 4, address width in bits; depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 8, word width in bits.

Ports:
- clk  input  1  rising-edge clock; all state changes on this edge.
- rst_n  input  1  asynchronous active-low reset; clears the output register only.
- we  input  1  write enable, sampled at posedge clk.
- addr  input  ADDR_WIDTH  word address for both read and write, sampled at posedge clk.
- din  input  DATA_WIDTH  write data, sampled at posedge clk when we=1.
- dout  output  DATA_WIDTH  registered read data.

Behaviour:
- Reset:
  - rst_n low forces dout to 0 immediately, independent of clk.
  - dout holds 0 until the first posedge after rst_n deasserts.
  - Memory contents are not reset. They are undefined (X in simulation) until written.
  - Reset asserted mid-operation: any write on that edge is ignored; dout is 0.
- Write: at posedge clk with rst_n=1 and we=1, mem[addr] <= din. Exactly one word is updated per cycle.
- Read latency is 1 cycle: at every posedge with rst_n=1, dout <= mem[addr] sampled at that edge. Reads happen whether we is 0 or 1.
- Read-during-write is read-first: when we=1, dout receives the OLD contents of mem[addr]. The new din is visible on dout one cycle later, provided addr is held with we=0.
- With we=0, dout tracks mem[addr] with 1-cycle latency. Back-to-back reads to different addresses give one new word per cycle.
- Full address range 0 .. 2**ADDR_WIDTH-1 is valid, with no wrap or aliasing. addr is always in range by construction.
- din is truncated or extended by the caller only; the block neither checks nor extends width.
- No handshake: the RAM accepts an operation every cycle and never stalls.

Optional Feature:
- Macro SPRAM_OUT_REG_EN.
- Defined:
  - A second output pipeline register is inserted after the array read register. Read latency becomes 2 cycles.
  - Both registers reset asynchronously to 0 on rst_n low.
  - Read-first semantics still apply at the first stage.
- Not defined (default): single output register, 1-cycle read latency, as specified above.

Decomposition:
- Package spram_pkg holds:
  - SPRAM_DEF_ADDR_WIDTH=4 and SPRAM_DEF_DATA_WIDTH=8.
  - Latency constant SPRAM_RD_LATENCY, 1 or 2 depending on SPRAM_OUT_REG_EN.
- One sub-module, spram_out_stage: a parameterised DATA_WIDTH register with asynchronous active-low clear. It is instantiated once, or twice under SPRAM_OUT_REG_EN.
- The array and write logic stay in single_port_ram so RAM inference is preserved.

Test Plan:
- Reset: assert rst_n=0 mid-simulation with dout nonzero -> dout=0 immediately, before the next clock edge; release -> next read returns array data.
- Clear-then-verify: write 0 to all 16 addresses with we=1, one per cycle; then read each with we=0 -> dout=0x00 one cycle after each address.
- Write/readback: for i=0..15 write i*3+5 to addr i (0x05, 0x08, ... 0x32); next cycle hold addr with we=0 -> dout equals the value written after 1 cycle.
- Read-first: mem[3]=0x0E, then write 0xAA to addr 3 -> dout=0x0E on that edge; next cycle with we=0 -> dout=0xAA.
- Streaming reads: addr 0,1,2,... on consecutive cycles with we=0 -> dout sequence 0x05, 0x08, 0x0B, ..., each lagging addr by exactly 1 cycle (2 with SPRAM_OUT_REG_EN).
- Boundary: write 0xFF to addr 15 and 0x01 to addr 0 -> reads return 0xFF and 0x01 respectively, with no aliasing between the two.

Source files
------------

// File: rtl/spram_pkg.sv
// -----------------------------------------------------------------------------
// spram_pkg
// Shared constants for the single-port RAM slice.
//   SPRAM_DEF_ADDR_WIDTH / SPRAM_DEF_DATA_WIDTH : default geometry (16 x 8).
//   SPRAM_RD_LATENCY : read latency in clocks from the address edge to dout.
//                      This is 2 when SPRAM_OUT_REG_EN is defined, else 1.
// Configuration macro: SPRAM_OUT_REG_EN (adds a second output register).
// -----------------------------------------------------------------------------
package spram_pkg;

  localparam int SPRAM_DEF_ADDR_WIDTH = 4;
  localparam int SPRAM_DEF_DATA_WIDTH = 8;

`ifdef SPRAM_OUT_REG_EN
  localparam int SPRAM_RD_LATENCY = 2;
`else
  localparam int SPRAM_RD_LATENCY = 1;
`endif

  // Number of words for a given address width.
  function automatic int spram_depth(input int addr_width);
    return 32'sd1 << addr_width;
  endfunction

endpackage

// File: rtl/spram_out_stage.sv
// -----------------------------------------------------------------------------
// spram_out_stage
// One DATA_WIDTH pipeline register with an asynchronous active-low clear.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low clear of q
//   d     : data captured on every rising edge
//   q     : registered data
// -----------------------------------------------------------------------------
module spram_out_stage #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  // Output register: cleared immediately by reset, otherwise loads d each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/single_port_ram.sv
// -----------------------------------------------------------------------------
// single_port_ram
// Synchronous single-port RAM with a shared read/write address and read-first
// read-during-write behaviour. The storage array is never reset. Only the
// output register(s) are cleared by rst_n.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears dout only)
//   we    : write enable, sampled at posedge clk
//   addr  : word address for both read and write
//   din   : write data
//   dout  : registered read data (latency spram_pkg::SPRAM_RD_LATENCY)
// Configuration macro: SPRAM_OUT_REG_EN adds a second output register, which
// makes the read latency 2 cycles.
// -----------------------------------------------------------------------------
module single_port_ram
  import spram_pkg::*;
#(
  parameter int ADDR_WIDTH = SPRAM_DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = SPRAM_DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int DEPTH = spram_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rd_stage1;

  // Array write port. The write is gated by rst_n so that an edge seen while
  // reset is asserted leaves the array untouched. The array itself has no reset.
  always_ff @(posedge clk) begin
    if (rst_n && we) begin
      mem[addr] <= din;
    end
  end

  // The read sees the array before this edge's write lands, which gives
  // read-first behaviour once rd_word is registered by the output stage.
  assign rd_word = mem[addr];

  spram_out_stage #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rd_stage1 (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rd_word),
    .q     (rd_stage1)
  );

`ifdef SPRAM_OUT_REG_EN
  spram_out_stage #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rd_stage2 (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rd_stage1),
    .q     (dout)
  );
`else
  assign dout = rd_stage1;
`endif

endmodule

// File: tb/tb_single_port_ram.sv
// -----------------------------------------------------------------------------
// tb_single_port_ram
// Self-checking bench for single_port_ram (16 x 8 default geometry).
// -----------------------------------------------------------------------------
module tb_single_port_ram;
  import spram_pkg::*;

  localparam int LAT = SPRAM_RD_LATENCY;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       we = 1'b0;
  logic [3:0] addr = 4'd0;
  logic [7:0] din = 8'd0;
  logic [7:0] dout;

  int checks = 0;
  int errors = 0;

  // Reference model: contents of every word, plus the history of words read
  // at each active edge since the last reset.
  logic [7:0] mem_model [16];
  logic [7:0] rd_hist [$];

  single_port_ram #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .addr  (addr),
    .din   (din),
    .dout  (dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: dout=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model update: a reset forgets the read history. Otherwise each edge records
  // the word at addr (its value before this edge's write) and then applies the write.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_hist.delete();
    end else begin
      rd_hist.push_back(mem_model[addr]);
      if (rd_hist.size() > LAT) void'(rd_hist.pop_front());
      if (we) mem_model[addr] <= din;
    end
  end

  // Per-cycle compare: dout must equal the word read LAT edges ago. It is 0
  // while in reset or before LAT edges have passed since reset. Words never written are skipped.
  always @(negedge clk) begin
    logic [7:0] exp_v;
    if (!rst_n || rd_hist.size() < LAT) exp_v = 8'h00;
    else exp_v = rd_hist[0];
    if (!$isunknown(exp_v)) check("model", dout, exp_v);
  end

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    we = 1'b1; addr = a; din = d;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic rd_lit(input logic [3:0] a, input logic [7:0] e, input string nm);
    we = 1'b0; addr = a;
    repeat (LAT) @(posedge clk);
    #1;
    check(nm, dout, e);
  endtask

  initial begin
    logic [7:0] v;
    #1;
    check("reset_init", dout, 8'h00);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Clear every word, then read each back.
    for (int i = 0; i < 16; i++) wr(4'(i), 8'h00);
    for (int i = 0; i < 16; i++) rd_lit(4'(i), 8'h00, "clear");

    // Write i*3+5 and read it back at the held address.
    for (int i = 0; i < 16; i++) begin
      v = 8'(i * 3 + 5);
      wr(4'(i), v);
      rd_lit(4'(i), v, "readback");
    end

    // Streaming reads: one new address per cycle, dout lags by LAT.
    we = 1'b0;
    for (int i = 0; i < 16 + LAT; i++) begin
      addr = (i < 16) ? 4'(i) : 4'd0;
      @(posedge clk); #1;
      if (i >= LAT - 1 && i - (LAT - 1) < 16) begin
        v = 8'((i - (LAT - 1)) * 3 + 5);
        check("stream", dout, v);
      end
    end

    // Read-first: writing 0xAA to addr 3 returns the old 0x0E first.
    we = 1'b1; addr = 4'd3; din = 8'hAA;
    @(posedge clk); #1;
    we = 1'b0;
    repeat (LAT - 1) begin @(posedge clk); #1; end
    check("rdfirst_old", dout, 8'h0E);
    @(posedge clk); #1;
    check("rdfirst_new", dout, 8'hAA);

    // Address boundaries: the top and bottom words are distinct.
    wr(4'd15, 8'hFF);
    wr(4'd0, 8'h01);
    rd_lit(4'd15, 8'hFF, "bound_hi");
    rd_lit(4'd0, 8'h01, "bound_lo");
    rd_lit(4'd15, 8'hFF, "bound_hi2");

    // Mid-operation reset: dout clears at once and a write on that edge is dropped.
    #2;
    rst_n = 1'b0; we = 1'b1; addr = 4'd5; din = 8'h77;
    #1 check("async_clr", dout, 8'h00);
    @(posedge clk); #1;
    check("rst_edge", dout, 8'h00);
    rst_n = 1'b1; we = 1'b0;
    #2 check("post_rel", dout, 8'h00);
    rd_lit(4'd5, 8'h14, "rst_nowrite");
    rd_lit(4'd15, 8'hFF, "post_rst_rd");

    repeat (2) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
